// File: rtl/free_list_ckpt_pkg.sv
// Shared sizing and id types for the checkpointed physical-register free list.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package free_list_ckpt_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ALLOC_PORTS   = 2;
    localparam int FREE_PORTS    = 2;
    localparam int NUM_CKPT      = 4;
    localparam int PW            = $clog2(NUM_PHYS_REGS);
    localparam int CW            = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef logic [PW-1:0] phys_id_t;
    typedef logic [CW-1:0] ckpt_id_t;
endpackage

// File: rtl/free_list_ckpt_if.sv
// Rename/commit-facing bundle of the free list: alloc, free, checkpoint, status.
// Latency: alloc outputs combinational; free_count/err registered.
// Backpressure: all-or-nothing grant; frees and checkpoints are always accepted.
interface free_list_ckpt_if
    import free_list_ckpt_pkg::*;
#(
    parameter int NPR = NUM_PHYS_REGS,
    parameter int AP  = ALLOC_PORTS,
    parameter int FP  = FREE_PORTS,
    parameter int NCK = NUM_CKPT
);
    localparam int IPW = $clog2(NPR);
    localparam int ICW = (NCK > 1) ? $clog2(NCK) : 1;

    logic [AP-1:0]      alloc_req;
    logic [AP*IPW-1:0]  alloc_phys;
    logic [AP-1:0]      alloc_valid;
    logic               alloc_gnt;
    logic [FP-1:0]      free_en;
    logic [FP*IPW-1:0]  free_phys;
    logic               ckpt_take;
    logic [ICW-1:0]     ckpt_take_id;
    logic               ckpt_restore;
    logic [ICW-1:0]     ckpt_restore_id;
    logic [IPW:0]       free_count;
    logic               err_double_free;

    modport slave (
        input  alloc_req, free_en, free_phys,
        input  ckpt_take, ckpt_take_id, ckpt_restore, ckpt_restore_id,
        output alloc_phys, alloc_valid, alloc_gnt, free_count, err_double_free
    );

    modport master (
        output alloc_req, free_en, free_phys,
        output ckpt_take, ckpt_take_id, ckpt_restore, ckpt_restore_id,
        input  alloc_phys, alloc_valid, alloc_gnt, free_count, err_double_free
    );
endinterface

// File: rtl/free_list_ckpt_pick.sv
// Selects the LANES lowest set bits of a vector and reports their ids (offset by BASE).
// Latency: purely combinational.
// Backpressure: none; lanes without a set bit report valid=0 and id=0.
module free_list_ckpt_pick
    import free_list_ckpt_pkg::*;
#(
    parameter int N     = NUM_PHYS_REGS - NUM_ARCH_REGS,
    parameter int BASE  = NUM_ARCH_REGS,
    parameter int LANES = ALLOC_PORTS,
    parameter int IDW   = PW
) (
    input  logic [N-1:0]         i_bits,
    output logic [LANES*IDW-1:0] o_ids,
    output logic [LANES-1:0]     o_valid
);
    int w_cnt;

    // Walk the vector upward; the n-th set bit found lands in lane n.
    always_comb begin
        w_cnt   = 0;
        o_ids   = '0;
        o_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (i_bits[i]) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_cnt == k) begin
                        o_ids[k*IDW +: IDW] = IDW'(i + BASE);
                        o_valid[k]          = 1'b1;
                    end
                end
                w_cnt = w_cnt + 1;
            end
        end
    end
endmodule

// File: rtl/free_list_ckpt.sv
// Multi-port physical-register free list with branch checkpoints and one-cycle restore.
// Latency: grant and ids combinational in the request cycle; free_count/err one cycle later.
// Backpressure: grant is all-or-nothing; a restore suppresses allocation for that cycle.
module free_list_ckpt
    import free_list_ckpt_pkg::*;
#(
    parameter int NPR = NUM_PHYS_REGS,
    parameter int NAR = NUM_ARCH_REGS,
    parameter int AP  = ALLOC_PORTS,
    parameter int FP  = FREE_PORTS,
    parameter int NCK = NUM_CKPT
) (
    input  logic              clk,
    input  logic              rst_n,
    free_list_ckpt_if.slave   bus
);
    localparam int LPW = $clog2(NPR);
    localparam int LCW = (NCK > 1) ? $clog2(NCK) : 1;
    // Architectural registers are permanently mapped and never enter the pool.
    localparam logic [NPR-1:0] RST_PAT = {NPR{1'b1}} << NAR;

    logic [NPR-1:0] r_free_bits;
    logic [NPR-1:0] r_ckpt_bits [NCK];
    logic [LPW:0]   r_free_count;
    logic           r_err_double_free;

    logic [NPR-1:0] w_grant_mask;
    logic [NPR-1:0] w_free_mask;
    logic [NPR-1:0] w_next_free;
    logic [LPW:0]   w_popcount;
    logic           w_double;
    logic           w_gnt;
    logic [LPW-1:0] w_fid;
    logic [LPW-1:0] w_gid;
    logic [AP*LPW-1:0] w_ids;
    logic [AP-1:0]     w_valid;

    free_list_ckpt_pick #(
        .N     (NPR - NAR),
        .BASE  (NAR),
        .LANES (AP),
        .IDW   (LPW)
    ) u_pick (
        .i_bits  (r_free_bits[NPR-1:NAR]),
        .o_ids   (w_ids),
        .o_valid (w_valid)
    );

    assign bus.alloc_phys  = w_ids;
    assign bus.alloc_valid = w_valid;

    // Grant only when every requested lane has a candidate and no restore is rewinding state.
    assign w_gnt = ~bus.ckpt_restore
                 & ((bus.alloc_req & ~w_valid) == '0)
                 & (|bus.alloc_req);
    assign bus.alloc_gnt = w_gnt;

    // Registers handed out this cycle.
    always_comb begin
        w_grant_mask = '0;
        w_gid        = '0;
        for (int k = 0; k < AP; k++) begin
            w_gid = w_ids[k*LPW +: LPW];
            if (w_gnt && bus.alloc_req[k]) begin
                w_grant_mask[w_gid] = 1'b1;
            end
        end
    end

    // Registers returned this cycle; a return of an already-free id (or twice in one cycle) is flagged.
    always_comb begin
        w_free_mask = '0;
        w_double    = 1'b0;
        w_fid       = '0;
        for (int j = 0; j < FP; j++) begin
            w_fid = bus.free_phys[j*LPW +: LPW];
            if (bus.free_en[j] && (int'(w_fid) >= NAR)) begin
                if (r_free_bits[w_fid] || w_free_mask[w_fid]) begin
                    w_double = 1'b1;
                end
                w_free_mask[w_fid] = 1'b1;
            end
        end
    end

    // Restore rewinds to the snapshot; commits this cycle are older than the branch so they still apply.
    always_comb begin
        if (bus.ckpt_restore) begin
            w_next_free = r_ckpt_bits[bus.ckpt_restore_id] | w_free_mask;
        end else begin
            w_next_free = (r_free_bits & ~w_grant_mask) | w_free_mask;
        end
    end

    // Population count of the next free vector, registered so it tracks free_bits exactly.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NPR; i++) begin
            w_popcount = w_popcount + (LPW+1)'(w_next_free[i]);
        end
    end

    // Live free vector, count and double-free pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_free_bits       <= RST_PAT;
            r_free_count      <= (LPW+1)'(NPR - NAR);
            r_err_double_free <= 1'b0;
        end else begin
            r_free_bits       <= w_next_free;
            r_free_count      <= w_popcount;
            r_err_double_free <= w_double;
        end
    end

    // Checkpoint slots: a take snapshots the next state; every other slot absorbs committed frees.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCK; c++) begin
            if (!rst_n) begin
                r_ckpt_bits[c] <= RST_PAT;
            end else if (bus.ckpt_take && !bus.ckpt_restore && (bus.ckpt_take_id == LCW'(c))) begin
                r_ckpt_bits[c] <= w_next_free;
            end else begin
                r_ckpt_bits[c] <= r_ckpt_bits[c] | w_free_mask;
            end
        end
    end

    assign bus.free_count      = r_free_count;
    assign bus.err_double_free = r_err_double_free;
endmodule

// File: tb/tb_free_list_ckpt.sv
// Self-checking bench for free_list_ckpt: directed scenarios plus randomized traffic vs a set-based model.
// Latency: checks combinational outputs mid-cycle, registered outputs after each edge.
// Backpressure: stimulus respects contiguous alloc requests; model predicts grant refusals.
module tb_free_list_ckpt;
    import free_list_ckpt_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    free_list_ckpt_if bus ();

    free_list_ckpt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: free set as a 64-bit vector, snapshots as whole copies.
    logic [63:0] m_free;
    logic [63:0] m_ckpt [4];
    int          m_count;
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [63:0] reset_set();
        logic [63:0] s = '0;
        for (int i = 32; i < 64; i++) s[i] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_free = reset_set();
        for (int c = 0; c < 4; c++) m_ckpt[c] = reset_set();
        m_count = 32;
        m_err   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.alloc_req       = '0;
        bus.free_en         = '0;
        bus.free_phys       = '0;
        bus.ckpt_take       = 1'b0;
        bus.ckpt_take_id    = '0;
        bus.ckpt_restore    = 1'b0;
        bus.ckpt_restore_id = '0;
    endtask

    // One cycle: drive, check combinational and registered outputs, advance model and DUT.
    task automatic step(input logic [1:0] req, input logic [1:0] fen, input int f0, input int f1,
                        input logic tk, input int tid, input logic rs, input int rid);
        int          cand [2];
        logic [1:0]  v;
        int          n;
        logic        g;
        logic [63:0] nxt;
        logic [63:0] seen;
        int          fid [2];
        bus.alloc_req       = req;
        bus.free_en         = fen;
        bus.free_phys       = {6'(f1), 6'(f0)};
        bus.ckpt_take       = tk;
        bus.ckpt_take_id    = 2'(tid);
        bus.ckpt_restore    = rs;
        bus.ckpt_restore_id = 2'(rid);
        #1;
        cand = '{0, 0};
        v = '0;
        n = 0;
        for (int i = 32; i < 64; i++) begin
            if (m_free[i] && n < 2) begin
                cand[n] = i;
                v[n] = 1'b1;
                n++;
            end
        end
        g = !rs && (req != 2'b00) && !(req[0] && !v[0]) && !(req[1] && !v[1]);
        chk("alloc_valid", 64'(bus.alloc_valid), 64'(v));
        chk("alloc_phys0", 64'(bus.alloc_phys[5:0]), 64'(cand[0]));
        chk("alloc_phys1", 64'(bus.alloc_phys[11:6]), 64'(cand[1]));
        chk("alloc_gnt", 64'(bus.alloc_gnt), 64'(g));
        chk("free_count", 64'(bus.free_count), 64'(m_count));
        chk("err_double_free", 64'(bus.err_double_free), 64'(m_err));
        nxt = rs ? m_ckpt[rid] : m_free;
        if (g) begin
            if (req[0]) nxt[cand[0]] = 1'b0;
            if (req[1]) nxt[cand[1]] = 1'b0;
        end
        fid[0] = f0;
        fid[1] = f1;
        seen = '0;
        m_err = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (fen[j] && fid[j] >= 32) begin
                if (m_free[fid[j]] || seen[fid[j]]) m_err = 1'b1;
                seen[fid[j]] = 1'b1;
            end
        end
        nxt = nxt | seen;
        for (int c = 0; c < 4; c++) m_ckpt[c] = m_ckpt[c] | seen;
        if (tk && !rs) m_ckpt[tid] = nxt;
        m_free  = nxt;
        m_count = $countones(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with traffic still on the bus; all of it must be discarded.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.alloc_req = 2'b11;
        bus.free_en   = 2'b11;
        bus.free_phys = {6'd40, 6'd41};
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
    endtask

    // Prefer ids currently allocated so frees are mostly legal; otherwise any id.
    function automatic int pick_id();
        if ($urandom_range(0, 9) < 7) begin
            int s = int'($urandom_range(0, 31));
            for (int k = 0; k < 32; k++) begin
                int id = 32 + ((s + k) % 32);
                if (!m_free[id]) return id;
            end
        end
        return int'($urandom_range(0, 63));
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state and first grants.
        chk("rst_count", 64'(bus.free_count), 64'd32);
        chk("rst_lane0", 64'(bus.alloc_phys[5:0]), 64'd32);
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("count_after_two", 64'(bus.free_count), 64'd28);
        chk("lane0_after_two", 64'(bus.alloc_phys[5:0]), 64'd36);

        // Drain to a single free register, then probe the empty boundary.
        for (int i = 0; i < 13; i++) step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("one_left", 64'(bus.free_count), 64'd1);
        chk("one_left_id", 64'(bus.alloc_phys[5:0]), 64'd63);
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("empty_count", 64'(bus.free_count), 64'd0);
        chk("empty_valid", 64'(bus.alloc_valid), 64'd0);
        step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0);

        // Ignored arch-reg free, legal free, then double free.
        step(2'b00, 2'b11, 40, 5, 0, 0, 0, 0);
        chk("free40_count", 64'(bus.free_count), 64'd1);
        step(2'b00, 2'b01, 40, 0, 0, 0, 0, 0);
        chk("dbl_pulse", 64'(bus.err_double_free), 64'd1);
        step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("dbl_clear", 64'(bus.err_double_free), 64'd0);
        step(2'b00, 2'b11, 41, 41, 0, 0, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // Checkpoint, younger allocations, a commit, then restore.
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1, 1, 0, 0);
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b00, 2'b01, 33, 0, 0, 0, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
        chk("restore_count", 64'(bus.free_count), 64'd31);
        chk("restore_lane0", 64'(bus.alloc_phys[5:0]), 64'd33);

        // Restore with alloc, free and take in the same cycle.
        step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        step(2'b11, 2'b01, 50, 0, 0, 0, 0, 0);
        step(2'b11, 2'b01, 35, 0, 1, 1, 1, 1);
        step(2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
        // Never-taken slot restores the reset pattern.
        step(2'b00, 2'b00, 0, 0, 0, 0, 1, 3);
        chk("untaken_slot", 64'(bus.free_count), 64'd32);

        // Mid-sequence reset with 20 allocated.
        for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_count", 64'(bus.free_count), 64'd12);
        do_reset();
        chk("post_reset_count", 64'(bus.free_count), 64'd32);
        chk("post_reset_lane0", 64'(bus.alloc_phys[5:0]), 64'd32);

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            int         r = int'($urandom_range(0, 2));
            logic [1:0] rq = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            logic [1:0] fe = 2'($urandom_range(0, 3));
            int         a = pick_id();
            int         b = pick_id();
            logic       tk = ($urandom_range(0, 5) == 0);
            logic       rs = ($urandom_range(0, 9) == 0);
            int         ti = int'($urandom_range(0, 3));
            int         ri = int'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(rq, fe, a, b, tk, ti, rs, ri);
            end
        end
        step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
